n_bit_piso_serializer: RTL and testbench

Parallel-in/serial-out transmitter, the transmit counterpart of the team's SIPO shift register. It accepts a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per clock, with framing strobes (first/last). Back-to-back words stream with no gap bits, so a SIPO receiver downstream can reassemble words continuously.

---
 rtl/n_bit_piso_serializer.sv | 78 +++++++
 tb/tb_n_bit_piso_serializer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/n_bit_piso_serializer.sv
// Parallel-in/serial-out transmitter: accepts a WIDTH-bit word on a valid/ready
// handshake and streams it one bit per clock with first/last framing strobes.
module n_bit_piso_serializer #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] i_parallel,
   input  logic             i_valid,
   output logic             o_ready,
   output logic             o_serial,
   output logic             o_serial_valid,
   output logic             o_first,
   output logic             o_last,
   output logic             o_busy
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   // Handshake: a word transfers at a posedge where i_valid && o_ready.
   // Upstream holds i_valid and i_parallel stable until that edge.
   state_t           r_state, w_state_nxt;
   logic [CW-1:0]    r_cnt, w_cnt_nxt;
   logic [WIDTH-1:0] r_shreg, w_shreg_nxt, w_shifted;
   logic             w_last, w_accept;

   assign w_last   = (r_state == SHIFT) && (r_cnt == LAST_CNT);
   assign o_ready  = !rst && ((r_state == IDLE) || w_last);
   assign w_accept = i_valid && o_ready;

   // The register always moves toward the end that drives o_serial.
   assign w_shifted = MSB_FIRST ? {r_shreg[WIDTH-2:0], 1'b0}
                                : {1'b0, r_shreg[WIDTH-1:1]};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_shreg <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_shreg <= w_shreg_nxt;
      end
   end

   // A reload on the last bit keeps the FSM in SHIFT so frames abut with no gap.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_shreg_nxt = r_shreg;
      if (w_accept) begin
         w_state_nxt = SHIFT;
         w_cnt_nxt   = '0;
         w_shreg_nxt = i_parallel;
      end else if (r_state == SHIFT) begin
         w_cnt_nxt   = r_cnt + CW'(1);
         w_shreg_nxt = w_shifted;
         if (w_last) begin
            w_state_nxt = IDLE;
         end
      end
   end

   assign o_busy         = (r_state == SHIFT);
   assign o_serial_valid = o_busy;
   assign o_serial       = o_busy && (MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0]);
   assign o_first        = o_busy && (r_cnt == '0);
   assign o_last         = w_last;

endmodule

// File: tb/tb_n_bit_piso_serializer.sv
// Bench for n_bit_piso_serializer: an MSB-first and an LSB-first instance run
// against a queue-of-bits reference model plus a word-reassembly scoreboard.
module tb_n_bit_piso_serializer;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [W-1:0] p_m = '0, p_l = '0;
   logic         v_m = 1'b0, v_l = 1'b0;
   logic         rdy_m, ser_m, sv_m, first_m, last_m, busy_m;
   logic         rdy_l, ser_l, sv_l, first_l, last_l, busy_l;

   int n_checks = 0;
   int n_errors = 0;

   // Model: each queue entry is one bit still to be shown, {first, last, bit};
   // entry 0 is the bit on the output in the current cycle.
   logic [2:0]   q_m[$];
   logic [2:0]   q_l[$];
   logic [W-1:0] exp_q_m[$];
   logic [W-1:0] exp_q_l[$];
   logic [W-1:0] asm_m = '0, asm_l = '0;
   bit           acc_m = 1'b0, acc_l = 1'b0;

   always #5 clk = ~clk;

   n_bit_piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
      .clk(clk), .rst(rst), .i_parallel(p_m), .i_valid(v_m), .o_ready(rdy_m),
      .o_serial(ser_m), .o_serial_valid(sv_m), .o_first(first_m),
      .o_last(last_m), .o_busy(busy_m)
   );

   n_bit_piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .rst(rst), .i_parallel(p_l), .i_valid(v_l), .o_ready(rdy_l),
      .o_serial(ser_l), .o_serial_valid(sv_l), .o_first(first_l),
      .o_last(last_l), .o_busy(busy_l)
   );

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic check_outputs();
      logic [2:0] rec;
      logic       ev;
      ev  = (q_m.size() > 0);
      rec = ev ? q_m[0] : 3'b000;
      check_eq("valid_m", sv_m, ev);
      check_eq("serial_m", ser_m, rec[0]);
      check_eq("first_m", first_m, rec[2]);
      check_eq("last_m", last_m, rec[1]);
      check_eq("busy_m", busy_m, ev);
      check_eq("ready_m", rdy_m, !rst && (q_m.size() <= 1));
      ev  = (q_l.size() > 0);
      rec = ev ? q_l[0] : 3'b000;
      check_eq("valid_l", sv_l, ev);
      check_eq("serial_l", ser_l, rec[0]);
      check_eq("first_l", first_l, rec[2]);
      check_eq("last_l", last_l, rec[1]);
      check_eq("busy_l", busy_l, ev);
      check_eq("ready_l", rdy_l, !rst && (q_l.size() <= 1));
      // Downstream SIPO view: reassemble each frame and compare whole words.
      if (sv_m === 1'b1) begin
         asm_m = {asm_m[W-2:0], ser_m};
         if (last_m === 1'b1) begin
            if (exp_q_m.size() > 0) check_eq("word_m", asm_m, exp_q_m.pop_front());
            else check_eq("word_m_unexpected", exp_q_m.size(), 1);
         end
      end
      if (sv_l === 1'b1) begin
         asm_l = {ser_l, asm_l[W-1:1]};
         if (last_l === 1'b1) begin
            if (exp_q_l.size() > 0) check_eq("word_l", asm_l, exp_q_l.pop_front());
            else check_eq("word_l_unexpected", exp_q_l.size(), 1);
         end
      end
   endtask

   task automatic model_edge();
      acc_m = !rst && v_m && (q_m.size() <= 1);
      acc_l = !rst && v_l && (q_l.size() <= 1);
      if (rst) begin
         q_m.delete(); exp_q_m.delete();
         q_l.delete(); exp_q_l.delete();
      end else begin
         if (q_m.size() > 0) void'(q_m.pop_front());
         if (q_l.size() > 0) void'(q_l.pop_front());
         if (acc_m) begin
            for (int i = 0; i < W; i++) q_m.push_back({i == 0, i == W - 1, p_m[W-1-i]});
            exp_q_m.push_back(p_m);
         end
         if (acc_l) begin
            for (int i = 0; i < W; i++) q_l.push_back({i == 0, i == W - 1, p_l[i]});
            exp_q_l.push_back(p_l);
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      check_outputs();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wait_acc_m();
      int n = 0;
      do begin tick(); n++; end while (!acc_m && n < 4 * W);
      if (!acc_m) check_eq("accept_timeout_m", 0, 1);
   endtask

   task automatic wait_acc_l();
      int n = 0;
      do begin tick(); n++; end while (!acc_l && n < 4 * W);
      if (!acc_l) check_eq("accept_timeout_l", 0, 1);
   endtask

   task automatic send_m(input logic [W-1:0] w);
      v_m = 1'b1; p_m = w;
      wait_acc_m();
      v_m = 1'b0;
   endtask

   task automatic send_l(input logic [W-1:0] w);
      v_l = 1'b1; p_l = w;
      wait_acc_l();
      v_l = 1'b0;
   endtask

   initial begin
      @(posedge clk);
      #1;
      // Reset held with a word offered: nothing may start.
      v_m = 1'b1; p_m = 8'hFF; v_l = 1'b1; p_l = 8'hFF;
      ticks(3);
      v_m = 1'b0; v_l = 1'b0; rst = 1'b0;
      tick();

      send_m(8'hA5);
      ticks(W + 2);
      send_l(8'h1E);
      ticks(W + 2);

      // Back-to-back frames with the word changing right after accept.
      v_m = 1'b1; p_m = 8'hF0;
      wait_acc_m();
      p_m = 8'h0F;
      wait_acc_m();
      v_m = 1'b0;
      ticks(W + 2);

      // Stall: new word offered mid-frame waits for the last bit.
      send_m(8'h81);
      ticks(2);
      v_m = 1'b1; p_m = 8'h3C;
      wait_acc_m();
      v_m = 1'b0;
      ticks(W + 2);

      // Mid-frame reset at bit 4, then a clean frame.
      send_m(8'hFF);
      send_l(8'hC3);
      ticks(3);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      send_m(8'h5A);
      ticks(W + 2);

      // Random traffic on both instances with occasional resets.
      for (int c = 0; c < 400; c++) begin
         if (!v_m || acc_m) begin
            v_m = ($urandom_range(0, 3) != 0);
            p_m = W'($urandom);
         end
         if (!v_l || acc_l) begin
            v_l = ($urandom_range(0, 2) != 0);
            p_l = W'($urandom);
         end
         rst = ($urandom_range(0, 63) == 0);
         tick();
      end
      rst = 1'b0; v_m = 1'b0; v_l = 1'b0;
      ticks(W + 3);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
